// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART RX FIFO: finds SYNC/LEN/payload/CHK frames and
// streams the payload as 16-bit little-endian samples over valid/ready.
module uart_frame_parser #(
    parameter int          N    = 4,
    parameter logic [7:0]  SYNC = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0][7:0]          fifo_data,
    input  logic [$clog2(N+1)-1:0]     fifo_can_pop,
    output logic [$clog2(N+1)-1:0]     fifo_pop,
    output logic [15:0]                sample_data,
    output logic                       sample_valid,
    input  logic                       sample_ready,
    output logic                       sample_last,
    output logic                       frame_ok,
    output logic                       frame_err,
    output logic                       busy
);

    localparam int PW = $clog2(N+1);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      chk_q, chk_d;
    logic [15:0]     sdata_q, sdata_d;
    logic            svalid_q, svalid_d;
    logic            slast_q, slast_d;
    logic            ok_q, ok_d;
    logic            err_q, err_d;
    logic [PW-1:0]   pop_c;
    logic            slot_free;

    // Only the two oldest bytes of the window are ever consumed.
    if (N > 2) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^fifo_data[N-1:2];
    end

    assign slot_free = !svalid_q || sample_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_HUNT;
            cnt_q    <= '0;
            chk_q    <= '0;
            sdata_q  <= '0;
            svalid_q <= 1'b0;
            slast_q  <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            chk_q    <= chk_d;
            sdata_q  <= sdata_d;
            svalid_q <= svalid_d;
            slast_q  <= slast_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        chk_d    = chk_q;
        sdata_d  = sdata_q;
        svalid_d = svalid_q;
        slast_d  = slast_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        pop_c    = '0;

        if (svalid_q && sample_ready) begin
            svalid_d = 1'b0;
            slast_d  = 1'b0;
        end

        case (state_q)
            ST_HUNT: begin
                if (fifo_can_pop >= PW'(1)) begin
                    pop_c = PW'(1);
                    if (fifo_data[0] == SYNC) state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (fifo_can_pop >= PW'(1)) begin
                    pop_c = PW'(1);
                    if (fifo_data[0] == 8'h00) begin
                        state_d = ST_HUNT;
                    end else begin
                        cnt_d   = fifo_data[0];
                        chk_d   = fifo_data[0];
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                // A pop overrides the handshake clear above, giving one sample per cycle.
                if (fifo_can_pop >= PW'(2) && slot_free) begin
                    pop_c    = PW'(2);
                    sdata_d  = {fifo_data[1], fifo_data[0]};
                    chk_d    = chk_q ^ fifo_data[0] ^ fifo_data[1];
                    cnt_d    = cnt_q - 8'd1;
                    svalid_d = 1'b1;
                    slast_d  = (cnt_q == 8'd1);
                    if (cnt_q == 8'd1) state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (fifo_can_pop >= PW'(1)) begin
                    pop_c   = PW'(1);
                    ok_d    = (fifo_data[0] == chk_q);
                    err_d   = (fifo_data[0] != chk_q);
                    state_d = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    assign fifo_pop     = rst ? '0 : pop_c;
    assign sample_data  = sdata_q;
    assign sample_valid = svalid_q;
    assign sample_last  = slast_q;
    assign frame_ok     = ok_q;
    assign frame_err    = err_q;
    assign busy         = (state_q != ST_HUNT);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: a FIFO model feeds bytes, expected
// samples/status are queued, and a monitor compares on every handshake/pulse.
`timescale 1ns/1ps
module tb_uart_frame_parser;

    localparam int N  = 4;
    localparam int PW = $clog2(N+1);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0][7:0]   fifo_data;
    logic [PW-1:0]       fifo_can_pop;
    logic [PW-1:0]       fifo_pop;
    logic [15:0]         sample_data;
    logic                sample_valid;
    logic                sample_ready;
    logic                sample_last;
    logic                frame_ok;
    logic                frame_err;
    logic                busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  fq[$];
    logic [7:0]  feed[$];
    logic [16:0] exp_s_q[$];
    logic        exp_f_q[$];

    int   gap         = 0;
    int   gap_ctr     = 0;
    int   rdy_low_cnt = 0;
    logic rdy_dflt    = 1'b1;
    int   last_pop    = 0;

    logic        mon_stalled = 1'b0;
    logic [16:0] mon_held    = '0;

    uart_frame_parser #(.N(N), .SYNC(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_data    (fifo_data),
        .fifo_can_pop (fifo_can_pop),
        .fifo_pop     (fifo_pop),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_last  (sample_last),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle of the FIFO model: retire last pop, admit arrivals, drive inputs,
    // then sample the combinational pop request for the coming edge.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < last_pop; i++) begin
            if (fq.size() > 0) fq.delete(0);
        end
        last_pop = 0;
        if (feed.size() > 0) begin
            if (gap == 0) begin
                while (feed.size() > 0) fq.push_back(feed.pop_front());
            end else begin
                gap_ctr++;
                if (gap_ctr >= gap) begin
                    gap_ctr = 0;
                    fq.push_back(feed.pop_front());
                end
            end
        end
        for (int i = 0; i < N; i++) fifo_data[i] = (i < fq.size()) ? fq[i] : 8'hEE;
        fifo_can_pop = PW'((fq.size() < N) ? fq.size() : N);
        if (rdy_low_cnt > 0) begin
            sample_ready = 1'b0;
            rdy_low_cnt--;
        end else begin
            sample_ready = rdy_dflt;
        end
        #1;
        if (rst) begin
            checks++;
            if (fifo_pop != '0) begin
                errors++;
                $display("FAIL pop_in_reset: got %0d want 0", fifo_pop);
            end
        end else begin
            last_pop = int'(fifo_pop);
            if (fifo_pop != '0) begin
                checks++;
                if (last_pop > int'(fifo_can_pop) ||
                    (last_pop == 2 && sample_valid && !sample_ready)) begin
                    errors++;
                    $display("FAIL pop_legal: got pop=%0d can_pop=%0d valid=%b ready=%b want pop<=can_pop and no 2-pop into full slot",
                             fifo_pop, fifo_can_pop, sample_valid, sample_ready);
                end
            end
        end
    endtask

    task automatic put_bytes(input int n, input logic [127:0] v);
        for (int i = 0; i < n; i++) feed.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic exp_s(input logic [15:0] d, input logic last);
        exp_s_q.push_back({d, last});
    endtask

    task automatic exp_f(input logic ok);
        exp_f_q.push_back(ok);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (!(feed.size() == 0 && fq.size() == 0 && exp_s_q.size() == 0 &&
                 exp_f_q.size() == 0 && !sample_valid) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_drain: got timeout after %0d cycles (samples left %0d, status left %0d) want drained",
                     name, n, exp_s_q.size(), exp_f_q.size());
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: got %b want 0", name, busy);
        end
    endtask

    // Monitor: sampled mid-cycle after the driver has settled the ready input.
    initial begin
        logic [16:0] e;
        logic        ef;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                mon_stalled = 1'b0;
            end else begin
                if (mon_stalled) begin
                    checks++;
                    if (!sample_valid || {sample_data, sample_last} != mon_held) begin
                        errors++;
                        $display("FAIL stall_hold: got valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                                 sample_valid, sample_data, sample_last, mon_held[16:1], mon_held[0]);
                    end
                end
                if (sample_valid && sample_ready) begin
                    checks++;
                    if (exp_s_q.size() == 0) begin
                        errors++;
                        $display("FAIL sample_extra: got data=%h last=%b want no sample", sample_data, sample_last);
                    end else begin
                        e = exp_s_q.pop_front();
                        if ({sample_data, sample_last} != e) begin
                            errors++;
                            $display("FAIL sample: got data=%h last=%b want data=%h last=%b",
                                     sample_data, sample_last, e[16:1], e[0]);
                        end
                    end
                end
                mon_stalled = sample_valid && !sample_ready;
                mon_held    = {sample_data, sample_last};
                if (frame_ok || frame_err) begin
                    checks++;
                    if (exp_f_q.size() == 0) begin
                        errors++;
                        $display("FAIL status_extra: got ok=%b err=%b want no pulse", frame_ok, frame_err);
                    end else begin
                        ef = exp_f_q.pop_front();
                        if (frame_ok != ef || frame_err != !ef) begin
                            errors++;
                            $display("FAIL status: got ok=%b err=%b want ok=%b err=%b",
                                     frame_ok, frame_err, ef, !ef);
                        end
                    end
                end
            end
        end
    end

    initial begin
        fifo_data    = '0;
        fifo_can_pop = '0;
        sample_ready = 1'b0;

        repeat (3) tick();
        checks++;
        if ({sample_valid, sample_last, frame_ok, frame_err, busy} != 5'b0 || sample_data != 16'h0) begin
            errors++;
            $display("FAIL reset_state: got v=%b l=%b ok=%b err=%b busy=%b data=%h want all 0",
                     sample_valid, sample_last, frame_ok, frame_err, busy, sample_data);
        end
        rst = 1'b0;

        // Good frame, ready high. CHK = 02^34^12^78^56 = 0A.
        put_bytes(7, 56'hA5_02_34_12_78_56_0A);
        exp_s(16'h1234, 1'b0);
        exp_s(16'h5678, 1'b1);
        exp_f(1'b1);
        wait_idle(100, "good");

        // Same frame with a wrong checksum.
        put_bytes(7, 56'hA5_02_34_12_78_56_00);
        exp_s(16'h1234, 1'b0);
        exp_s(16'h5678, 1'b1);
        exp_f(1'b0);
        wait_idle(100, "badchk");

        // Leading garbage dropped in HUNT. CHK = 01^CD^AB = 67.
        put_bytes(8, 64'h00_FF_13_A5_01_CD_AB_67);
        exp_s(16'hABCD, 1'b1);
        exp_f(1'b1);
        wait_idle(100, "garbage");

        // Zero-length header then a normal frame. CHK = 01^34^12 = 27.
        put_bytes(7, 56'hA5_00_A5_01_34_12_27);
        exp_s(16'h1234, 1'b1);
        exp_f(1'b1);
        wait_idle(100, "zerolen");

        // Slow byte arrival plus a 5-cycle ready stall. CHK = 04^11^..^88 = 8C.
        gap = 10;
        put_bytes(11, 88'hA5_04_11_22_33_44_55_66_77_88_8C);
        exp_s(16'h2211, 1'b0);
        exp_s(16'h4433, 1'b0);
        exp_s(16'h6655, 1'b0);
        exp_s(16'h8877, 1'b1);
        exp_f(1'b1);
        begin
            int n = 0;
            while (last_pop != 2 && n < 100) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 100) begin
                errors++;
                $display("FAIL throttle_first_pop: got timeout want a 2-byte pop");
            end
            rdy_low_cnt = 5;
        end
        wait_idle(400, "throttle");
        gap     = 0;
        gap_ctr = 0;

        // Reset while a sample is stalled in PAYLOAD.
        rdy_dflt = 1'b0;
        put_bytes(8, 64'hA5_03_01_02_03_04_05_06);
        repeat (6) tick();
        checks++;
        if (!(sample_valid && busy && sample_data == 16'h0201)) begin
            errors++;
            $display("FAIL pre_reset: got v=%b busy=%b data=%h want v=1 busy=1 data=0201",
                     sample_valid, busy, sample_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({sample_valid, sample_last, frame_ok, frame_err, busy} != 5'b0 ||
            sample_data != 16'h0 || fifo_pop != '0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b l=%b ok=%b err=%b busy=%b data=%h pop=%0d want all 0",
                     sample_valid, sample_last, frame_ok, frame_err, busy, sample_data, fifo_pop);
        end
        fq.delete();
        feed.delete();
        last_pop = 0;
        repeat (2) tick();
        rst      = 1'b0;
        rdy_dflt = 1'b1;

        put_bytes(5, 40'hA5_01_CD_AB_67);
        exp_s(16'hABCD, 1'b1);
        exp_f(1'b1);
        wait_idle(100, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
